// File: rtl/pwm_pkg.sv
// Shared types and helpers for the PWM ramp controller.
// Contents: controller state enum, default data width, saturating step-toward function.
// Users: pwm_ramp_ctrl, pwm_period_tick.
package pwm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RAMP  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_e;

  localparam int W_DEF = 8;

  // Move cur toward target by step, stopping exactly on target.
  // The add is done one bit wider than the operands so it can never wrap around.
  function automatic logic [31:0] step_toward(input logic [31:0] cur,
                                              input logic [31:0] target,
                                              input logic [31:0] step);
    logic [32:0] up;
    logic [31:0] nxt;
    up  = {1'b0, cur} + {1'b0, step};
    nxt = cur;
    if (cur < target) begin
      nxt = (up > {1'b0, target}) ? target : up[31:0];
    end else if (cur > target) begin
      nxt = ((cur - target) < step) ? target : (cur - step);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/pwm_period_tick.sv
// PWM period-wrap detector with a ramp tick divider.
// Ports: clock/reset (sync, active-low); clear zeroes the hold counter; pwm_inc/pwm_cont/pwm_T
// describe the running PWM; wrap pulses when the counter hits its max, tick on every HOLD-th wrap.
module pwm_period_tick
  import pwm_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int HOLD = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         pwm_inc,
  input  logic [W-1:0] pwm_cont,
  input  logic [W-1:0] pwm_T,
  output logic         wrap,
  output logic         tick
);

  localparam int            CW   = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [CW-1:0] LAST = CW'(HOLD - 1);

  logic [CW-1:0] hold_cnt_q, hold_cnt_d;

  assign wrap = pwm_inc && (pwm_cont == pwm_T);
  assign tick = wrap && (hold_cnt_q == LAST);

  // clear has priority so a config applied on a tick wrap restarts the hold interval.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (clear) begin
      hold_cnt_d = '0;
    end else if (tick) begin
      hold_cnt_d = '0;
    end else if (wrap) begin
      hold_cnt_d = hold_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      hold_cnt_q <= '0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
    end
  end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Sequencing controller for the PWM: shadows configs, applies them at period boundaries, soft-ramps duty.
// Ports: clock/reset (sync, active-low); cfg_* valid/ready config input; pwm_cont counter feedback;
// pwm_inc/pwm_T/pwm_duty drive the PWM; busy = not IDLE; at_target = RUN with duty on target.
module pwm_ramp_ctrl
  import pwm_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int STEP = 1,
  parameter int HOLD = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         cfg_valid,
  output logic         cfg_ready,
  input  logic [W-1:0] cfg_T,
  input  logic [W-1:0] cfg_duty,
  input  logic         cfg_enable,
  input  logic [W-1:0] pwm_cont,
  output logic         pwm_inc,
  output logic [W-1:0] pwm_T,
  output logic [W-1:0] pwm_duty,
  output logic         busy,
  output logic         at_target
);

  state_e       state_q, state_d;
  logic         pwm_inc_q, pwm_inc_d;
  logic [W-1:0] pwm_T_q, pwm_T_d;
  logic [W-1:0] pwm_duty_q, pwm_duty_d;
  logic [W-1:0] target_q, target_d;
  logic [W-1:0] shadow_T_q, shadow_T_d;
  logic [W-1:0] shadow_duty_q, shadow_duty_d;
  logic         shadow_en_q, shadow_en_d;
  logic         pending_q, pending_d;

  logic         transfer, apply, clear, wrap, tick;
  logic [W-1:0] ramp_duty, clamp_duty, new_target;

  pwm_period_tick #(.W(W), .HOLD(HOLD)) u_tick (
    .clock    (clock),
    .reset    (reset),
    .clear    (clear),
    .pwm_inc  (pwm_inc_q),
    .pwm_cont (pwm_cont),
    .pwm_T    (pwm_T_q),
    .wrap     (wrap),
    .tick     (tick)
  );

  assign transfer   = cfg_valid && !pending_q;
  // pending_q is only visible the cycle after transfer, so a wrap in the transfer cycle never applies.
  assign apply      = pending_q && wrap && (state_q != IDLE);
  assign ramp_duty  = W'(step_toward(32'(pwm_duty_q), 32'(target_q), 32'(STEP)));
  assign clamp_duty = (pwm_duty_q > shadow_T_q) ? shadow_T_q : pwm_duty_q;
  assign new_target = shadow_en_q ? shadow_duty_q : '0;
  assign clear      = apply || (state_d != state_q);

  always_comb begin
    state_d       = state_q;
    pwm_inc_d     = pwm_inc_q;
    pwm_T_d       = pwm_T_q;
    pwm_duty_d    = pwm_duty_q;
    target_d      = target_q;
    shadow_T_d    = shadow_T_q;
    shadow_duty_d = shadow_duty_q;
    shadow_en_d   = shadow_en_q;
    pending_d     = pending_q;

    if (state_q == IDLE) begin
      // From IDLE the PWM starts immediately, always from zero duty.
      if (pending_q) begin
        pending_d = 1'b0;
        if (shadow_en_q) begin
          pwm_inc_d  = 1'b1;
          pwm_T_d    = shadow_T_q;
          pwm_duty_d = '0;
          target_d   = shadow_duty_q;
          state_d    = RAMP;
        end
      end
    end else if (apply) begin
      // Application takes the whole wrap; any ramp tick on this wrap is dropped.
      pending_d  = 1'b0;
      pwm_T_d    = shadow_T_q;
      pwm_duty_d = clamp_duty;
      target_d   = new_target;
      if (!shadow_en_q) begin
        state_d = DRAIN;
      end else if (state_q == DRAIN) begin
        state_d = RAMP;
      end else begin
        state_d = (clamp_duty == new_target) ? RUN : RAMP;
      end
    end else begin
      case (state_q)
        RAMP: begin
          if (tick) begin
            pwm_duty_d = ramp_duty;
            if (ramp_duty == target_q) begin
              state_d = RUN;
            end
          end
        end
        DRAIN: begin
          if (wrap && (pwm_duty_q == '0)) begin
            pwm_inc_d = 1'b0;
            pwm_T_d   = '0;
            state_d   = IDLE;
          end else if (tick) begin
            pwm_duty_d = ramp_duty;
          end
        end
        default: begin
        end
      endcase
    end

    if (transfer) begin
      shadow_T_d    = cfg_T;
      shadow_duty_d = (cfg_duty > cfg_T) ? cfg_T : cfg_duty;
      shadow_en_d   = cfg_enable;
      pending_d     = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= IDLE;
      pwm_inc_q     <= 1'b0;
      pwm_T_q       <= '0;
      pwm_duty_q    <= '0;
      target_q      <= '0;
      shadow_T_q    <= '0;
      shadow_duty_q <= '0;
      shadow_en_q   <= 1'b0;
      pending_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      pwm_inc_q     <= pwm_inc_d;
      pwm_T_q       <= pwm_T_d;
      pwm_duty_q    <= pwm_duty_d;
      target_q      <= target_d;
      shadow_T_q    <= shadow_T_d;
      shadow_duty_q <= shadow_duty_d;
      shadow_en_q   <= shadow_en_d;
      pending_q     <= pending_d;
    end
  end

  assign cfg_ready = !pending_q;
  assign pwm_inc   = pwm_inc_q;
  assign pwm_T     = pwm_T_q;
  assign pwm_duty  = pwm_duty_q;
  assign busy      = (state_q != IDLE);
  assign at_target = (state_q == RUN) && (pwm_duty_q == target_q);

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Testbench for pwm_ramp_ctrl: two instances (STEP=1/HOLD=1 and STEP=2/HOLD=2) share the config stream,
// each checked every cycle against a behavioural model of the controller rules.
// Directed config sequence first, then randomized configs, counter feedback and mid-run resets.
module tb_pwm_ramp_ctrl;

  localparam int M_IDLE = 0, M_RAMP = 1, M_RUN = 2, M_DRAIN = 3;

  logic       clock = 1'b0;
  logic       reset;
  logic       cfg_valid;
  logic [7:0] cfg_T, cfg_duty;
  logic       cfg_enable;
  logic [7:0] cont_a, cont_b;

  logic       cfg_ready_a, pwm_inc_a, busy_a, at_target_a;
  logic [7:0] pwm_T_a, pwm_duty_a;
  logic       cfg_ready_b, pwm_inc_b, busy_b, at_target_b;
  logic [7:0] pwm_T_b, pwm_duty_b;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit force_wrap;

  // Model state, one slot per instance.
  int steps[2] = '{1, 2};
  int holds[2] = '{1, 2};
  int m_mode[2], m_inc[2], m_T[2], m_duty[2], m_tgt[2];
  int m_pend[2], m_shT[2], m_shD[2], m_shE[2], m_wraps[2];

  always #5 clock = ~clock;

  pwm_ramp_ctrl #(.W(8), .STEP(1), .HOLD(1)) u_dut_a (
    .clock(clock), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready_a),
    .cfg_T(cfg_T), .cfg_duty(cfg_duty), .cfg_enable(cfg_enable), .pwm_cont(cont_a),
    .pwm_inc(pwm_inc_a), .pwm_T(pwm_T_a), .pwm_duty(pwm_duty_a),
    .busy(busy_a), .at_target(at_target_a)
  );

  pwm_ramp_ctrl #(.W(8), .STEP(2), .HOLD(2)) u_dut_b (
    .clock(clock), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready_b),
    .cfg_T(cfg_T), .cfg_duty(cfg_duty), .cfg_enable(cfg_enable), .pwm_cont(cont_b),
    .pwm_inc(pwm_inc_b), .pwm_T(pwm_T_b), .pwm_duty(pwm_duty_b),
    .busy(busy_b), .at_target(at_target_b)
  );

  task automatic chk_val(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0d want=%0d", tag, cyc, obs, exp);
    end
  endtask

  function automatic int toward(input int cur, input int tgt, input int step);
    if (cur < tgt) return (cur + step > tgt) ? tgt : cur + step;
    if (cur > tgt) return (cur - step < tgt) ? tgt : cur - step;
    return cur;
  endfunction

  // One clock of the controller rules, using the inputs present at the edge.
  task automatic model_step(input int i, input int cont);
    int  nmode;
    bit  wrap, xfer, tick;
    if (!reset) begin
      m_mode[i] = M_IDLE; m_inc[i] = 0; m_T[i] = 0; m_duty[i] = 0; m_tgt[i] = 0;
      m_pend[i] = 0; m_shT[i] = 0; m_shD[i] = 0; m_shE[i] = 0; m_wraps[i] = 0;
      return;
    end
    wrap  = (m_inc[i] != 0) && (cont == m_T[i]);
    xfer  = cfg_valid && (m_pend[i] == 0);
    nmode = m_mode[i];
    if (m_mode[i] == M_IDLE) begin
      if (m_pend[i] != 0) begin
        if (m_shE[i] != 0) begin
          m_T[i] = m_shT[i]; m_duty[i] = 0; m_inc[i] = 1; m_tgt[i] = m_shD[i];
          nmode = M_RAMP;
        end
        m_pend[i] = 0;
      end
    end else if (wrap) begin
      if (m_pend[i] != 0) begin
        m_T[i] = m_shT[i];
        if (m_duty[i] > m_shT[i]) m_duty[i] = m_shT[i];
        m_tgt[i] = (m_shE[i] != 0) ? m_shD[i] : 0;
        if (m_shE[i] == 0) nmode = M_DRAIN;
        else if (m_mode[i] == M_DRAIN) nmode = M_RAMP;
        else nmode = (m_duty[i] == m_tgt[i]) ? M_RUN : M_RAMP;
        m_pend[i]  = 0;
        m_wraps[i] = 0;
      end else begin
        m_wraps[i]++;
        tick = (m_wraps[i] >= holds[i]);
        if (tick) m_wraps[i] = 0;
        if (m_mode[i] == M_DRAIN && m_duty[i] == 0) begin
          nmode = M_IDLE; m_inc[i] = 0; m_T[i] = 0;
        end else if (tick && m_mode[i] != M_RUN) begin
          m_duty[i] = toward(m_duty[i], m_tgt[i], steps[i]);
          if (m_mode[i] == M_RAMP && m_duty[i] == m_tgt[i]) nmode = M_RUN;
        end
      end
    end
    if (nmode != m_mode[i]) m_wraps[i] = 0;
    m_mode[i] = nmode;
    if (xfer) begin
      m_shT[i]  = int'(cfg_T);
      m_shD[i]  = (int'(cfg_duty) < int'(cfg_T)) ? int'(cfg_duty) : int'(cfg_T);
      m_shE[i]  = int'(cfg_enable);
      m_pend[i] = 1;
    end
  endtask

  task automatic check_dut(input int i, input logic inc, input logic [7:0] t, input logic [7:0] duty,
                           input logic rdy, input logic bsy, input logic at);
    chk_val($sformatf("pwm_inc[%0d]", i), int'(inc), m_inc[i]);
    chk_val($sformatf("pwm_T[%0d]", i), int'(t), m_T[i]);
    chk_val($sformatf("pwm_duty[%0d]", i), int'(duty), m_duty[i]);
    chk_val($sformatf("cfg_ready[%0d]", i), int'(rdy), (m_pend[i] == 0) ? 1 : 0);
    chk_val($sformatf("busy[%0d]", i), int'(bsy), (m_mode[i] != M_IDLE) ? 1 : 0);
    chk_val($sformatf("at_target[%0d]", i), int'(at),
            (m_mode[i] == M_RUN && m_duty[i] == m_tgt[i]) ? 1 : 0);
    chk_val($sformatf("duty_le_T[%0d]", i), (duty <= t) ? 1 : 0, 1);
  endtask

  function automatic logic [7:0] pick_cont(input int i);
    if (force_wrap || $urandom_range(0, 1) == 1) return 8'(m_T[i]);
    return 8'($urandom_range(0, 15));
  endfunction

  task automatic run_cycle();
    @(posedge clock);
    model_step(0, int'(cont_a));
    model_step(1, int'(cont_b));
    @(negedge clock);
    cyc++;
    check_dut(0, pwm_inc_a, pwm_T_a, pwm_duty_a, cfg_ready_a, busy_a, at_target_a);
    check_dut(1, pwm_inc_b, pwm_T_b, pwm_duty_b, cfg_ready_b, busy_b, at_target_b);
    cont_a = pick_cont(0);
    cont_b = pick_cont(1);
  endtask

  task automatic offer_cfg(input int t, input int d, input int en, input int hold_cycles);
    cfg_valid  = 1'b1;
    cfg_T      = 8'(t);
    cfg_duty   = 8'(d);
    cfg_enable = (en != 0);
    run_cycle();
    cfg_valid = 1'b0;
    repeat (hold_cycles) run_cycle();
  endtask

  initial begin
    int rst_left;
    reset      = 1'b0;
    cfg_valid  = 1'b0;
    cfg_T      = '0;
    cfg_duty   = '0;
    cfg_enable = 1'b0;
    cont_a     = '0;
    cont_b     = '0;
    force_wrap = 1'b1;
    repeat (2) run_cycle();
    reset = 1'b1;

    // Directed: start-up ramp, clamped target, period shrink in RUN, soft-stop drain.
    offer_cfg(9, 3, 1, 12);
    offer_cfg(50, 200, 1, 110);
    offer_cfg(20, 15, 1, 40);
    offer_cfg(10, 15, 1, 10);
    offer_cfg(9, 4, 1, 20);
    offer_cfg(9, 4, 0, 20);
    // Reset in the middle of a ramp, then a back-to-back offer while pending.
    offer_cfg(9, 6, 1, 4);
    reset = 1'b0;
    repeat (2) run_cycle();
    reset = 1'b1;
    run_cycle();
    cfg_valid = 1'b1; cfg_T = 8'd12; cfg_duty = 8'd5; cfg_enable = 1'b1;
    repeat (3) run_cycle();
    cfg_valid = 1'b0;
    repeat (20) run_cycle();

    // Randomized configs, counter feedback and occasional two-cycle resets.
    force_wrap = 1'b0;
    rst_left   = 0;
    for (int n = 0; n < 3000; n++) begin
      if (rst_left == 0 && $urandom_range(0, 399) == 0) rst_left = 2;
      reset = (rst_left == 0);
      if (rst_left > 0) rst_left--;
      cfg_valid  = ($urandom_range(0, 7) == 0);
      cfg_T      = 8'($urandom_range(0, 15));
      cfg_duty   = 8'($urandom_range(0, 20));
      cfg_enable = ($urandom_range(0, 4) != 0);
      run_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
